// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    localparam int RF_WIDTH_DEFAULT = 32;
    localparam int RF_DEPTH_DEFAULT = 32;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: range check, zero-register masking and write->read forwarding.
module regfile_rdport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             i_ready,
    input  logic [AW-1:0]    i_ra,
    input  logic             i_weA,
    input  logic [AW-1:0]    i_waA,
    input  logic [WIDTH-1:0] i_wdA,
    input  logic             i_weB,
    input  logic [AW-1:0]    i_waB,
    input  logic [WIDTH-1:0] i_wdB,
    input  logic [WIDTH-1:0] i_mem [DEPTH],
    output logic [WIDTH-1:0] o_rd
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic w_inRange;
    logic w_isZero;

    assign w_inRange = ({1'b0, i_ra} < DEPTH_LIM);
    assign w_isZero  = ZERO_REG && (i_ra == '0);

    // Port B takes priority over A so forwarding agrees with the B-wins write rule.
    always_comb begin
        o_rd = '0;
        if (i_ready && w_inRange && !w_isZero) begin
            if (BYPASS && i_weB && (i_waB == i_ra)) begin
                o_rd = i_wdB;
            end else if (BYPASS && i_weA && (i_waA == i_ra)) begin
                o_rd = i_wdA;
            end else begin
                o_rd = i_mem[i_ra];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD combinational read ports and a
// post-reset clear sequencer that zeroes every entry before the file becomes usable.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEFAULT,
    parameter int DEPTH    = RF_DEPTH_DEFAULT,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   init_done,
    input  logic                   we_a,
    input  logic [AW-1:0]          wa_a,
    input  logic [WIDTH-1:0]       wd_a,
    input  logic                   we_b,
    input  logic [AW-1:0]          wa_b,
    input  logic [WIDTH-1:0]       wd_b,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    rf_state_e        r_state;
    rf_state_e        w_stateNext;
    logic [AW-1:0]    r_clrCnt;
    logic             w_clrLast;
    logic             w_ready;
    logic             w_weA;
    logic             w_weB;

    assign w_ready   = (r_state == RF_READY);
    assign init_done = w_ready;
    assign w_clrLast = (r_clrCnt == AW'(DEPTH - 1));

    // Writes outside the array or to a hardwired zero register are simply dropped.
    assign w_weA = we_a && ({1'b0, wa_a} < DEPTH_LIM) && !(ZERO_REG && (wa_a == '0));
    assign w_weB = we_b && ({1'b0, wa_b} < DEPTH_LIM) && !(ZERO_REG && (wa_b == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RF_CLEAR;
            r_clrCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == RF_CLEAR) begin
                r_clrCnt <= w_clrLast ? '0 : r_clrCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if ((r_state == RF_CLEAR) && w_clrLast) begin
            w_stateNext = RF_READY;
        end
    end

    // Storage has no reset of its own; it is zeroed by the clear walk instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == RF_CLEAR) begin
                r_mem[r_clrCnt] <= '0;
            end else begin
                if (w_weA) begin
                    r_mem[wa_a] <= wd_a;
                end
                if (w_weB) begin
                    r_mem[wa_b] <= wd_b;
                end
            end
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rdPort
        regfile_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdPort (
            .i_ready (w_ready),
            .i_ra    (ra[g*AW +: AW]),
            .i_weA   (we_a),
            .i_waA   (wa_a),
            .i_wdA   (wd_a),
            .i_weB   (we_b),
            .i_waB   (wa_b),
            .i_wdB   (wd_b),
            .i_mem   (r_mem),
            .o_rd    (rd[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: three register-file configurations driven from shared stimulus and
// compared every cycle against an array-based model of the register-file rules.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        we_a, we_b;
    logic [4:0]  wa_a, wa_b;
    logic [31:0] wd_a, wd_b;
    logic [9:0]  ra;
    logic [19:0] ra2;
    logic [63:0] rd0, rd1, rd2;
    logic        done0, done1, done2;

    int passCount  = 0;
    int checkCount = 0;
    bit checking   = 0;

    // Model state: cycles since reset release, per-configuration storage and properties.
    int          cnt = 0;
    logic [31:0] mMem [3][32];
    int          mDepth [3] = '{32, 32, 24};
    bit          mZero  [3] = '{1'b1, 1'b0, 1'b1};
    bit          mByp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mMask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .init_done(done0),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra(ra), .rd(rd0));

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .init_done(done1),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra(ra), .rd(rd1));

    regfile_mp #(.WIDTH(16), .DEPTH(24), .NREAD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .init_done(done2),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a[15:0]), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b[15:0]),
        .ra(ra2), .rd(rd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic bit mReady(input int k);
        return cnt >= mDepth[k];
    endfunction

    // What a read of addr must return for configuration k with the current inputs.
    function automatic logic [31:0] expRead(input int k, input int addr);
        if (!mReady(k) || addr >= mDepth[k] || (mZero[k] && addr == 0)) return 32'h0;
        if (mByp[k] && we_b && int'(wa_b) == addr) return wd_b & mMask[k];
        if (mByp[k] && we_a && int'(wa_a) == addr) return wd_a & mMask[k];
        return mMem[k][addr];
    endfunction

    function automatic void mWrite(input int k, input int addr, input logic [31:0] data);
        if (addr < mDepth[k] && !(mZero[k] && addr == 0)) mMem[k][addr] = data & mMask[k];
    endfunction

    // Model update: a file becomes usable, fully zeroed, DEPTH edges after reset release.
    always @(posedge clk) begin
        if (reset) begin
            cnt = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mReady(k)) begin
                    if (we_a) mWrite(k, int'(wa_a), wd_a);
                    if (we_b) mWrite(k, int'(wa_b), wd_b);
                end else if (cnt + 1 == mDepth[k]) begin
                    for (int a = 0; a < 32; a++) mMem[k][a] = 32'h0;
                end
            end
            if (cnt < 1000) cnt = cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("done0", {63'h0, done0}, {63'h0, mReady(0)});
            checkOutput("done1", {63'h0, done1}, {63'h0, mReady(1)});
            checkOutput("done2", {63'h0, done2}, {63'h0, mReady(2)});
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("dut0.rd%0d", p), {32'h0, rd0[p*32 +: 32]},
                            {32'h0, expRead(0, int'(ra[p*5 +: 5]))});
                checkOutput($sformatf("dut1.rd%0d", p), {32'h0, rd1[p*32 +: 32]},
                            {32'h0, expRead(1, int'(ra[p*5 +: 5]))});
            end
            for (int p = 0; p < 4; p++) begin
                checkOutput($sformatf("dut2.rd%0d", p), {48'h0, rd2[p*16 +: 16]},
                            {32'h0, expRead(2, int'(ra2[p*5 +: 5]))});
            end
        end
    end

    task automatic applyStimulus(input logic weA, input logic [4:0] waA, input logic [31:0] wdA,
                                 input logic weB, input logic [4:0] waB, input logic [31:0] wdB,
                                 input logic [9:0] raV, input logic [19:0] ra2V);
        @(posedge clk);
        #1;
        we_a = weA; wa_a = waA; wd_a = wdA;
        we_b = weB; wa_b = waB; wd_b = wdB;
        ra = raV; ra2 = ra2V;
    endtask

    // Counts edges from release until init_done of dut0 rises; also notes when dut2 rises.
    task automatic countInit(output int n, output int n2);
        n = 0;
        n2 = 0;
        while (!done0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done2 && n2 == 0) n2 = n;
        end
    endtask

    initial begin
        int n, n2;
        reset = 1'b1;
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        ra = {5'd5, 5'd3};
        ra2 = {5'd1, 5'd2, 5'd3, 5'd4};
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear sequence timing after a clean release.
        countInit(n, n2);
        checkOutput("initLatency32", 64'(n), 64'd32);
        checkOutput("initLatency24", 64'(n2), 64'd24);

        // Same-cycle forwarding vs. next-cycle visibility.
        applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, {5'd0, 5'd5}, {15'h0, 5'd5});
        #2;
        checkOutput("bypassA", {32'h0, rd0[31:0]}, 64'h0000_0000_DEAD_BEEF);
        checkOutput("noBypassPre", {32'h0, rd1[31:0]}, 64'h0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'd0, 5'd5}, {15'h0, 5'd5});
        #2;
        checkOutput("noBypassPost", {32'h0, rd1[31:0]}, 64'h0000_0000_DEAD_BEEF);
        checkOutput("narrowWrite", {48'h0, rd2[15:0]}, 64'h0000_0000_0000_BEEF);

        // Both ports on the same address: B wins.
        applyStimulus(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, {5'd7, 5'd7}, {15'h0, 5'd7});
        #2;
        checkOutput("collideBypass", {32'h0, rd0[63:32]}, 64'h22);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'd7, 5'd7}, {15'h0, 5'd7});
        #2;
        checkOutput("collideStored", {32'h0, rd1[31:0]}, 64'h22);

        // Writes to register 0.
        applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, {5'd0, 5'd0}, 20'h0);
        #2;
        checkOutput("zeroRegSame", {32'h0, rd0[31:0]}, 64'h0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'd0, 5'd0}, 20'h0);
        #2;
        checkOutput("zeroRegNext", {32'h0, rd0[31:0]}, 64'h0);
        checkOutput("plainReg0", {32'h0, rd1[31:0]}, 64'h0000_0000_FFFF_FFFF);

        // Narrow/shallow file: in-range write, zero reg, last entry, out-of-range address.
        applyStimulus(1, 5'd20, 32'h0000_ABCD, 1, 5'd30, 32'h0000_5555, 10'h0,
                      {5'd30, 5'd23, 5'd0, 5'd20});
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 10'h0, {5'd30, 5'd23, 5'd0, 5'd20});
        #2;
        checkOutput("dut2Ports", rd2, 64'h0000_0000_0000_ABCD);

        // Fill r1..r31, then interrupt a clear sequence partway through.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'h0, {5'(31 - i), 5'(i)},
                          {5'(i), 5'(i - 1), 5'(31 - i), 5'(i)});
        end
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'd31, 5'd17}, {15'h0, 5'd17});
        #2;
        checkOutput("filled17", {32'h0, rd0[31:0]}, 64'h111);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        countInit(n, n2);
        checkOutput("restartLatency", 64'(n), 64'd32);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'd0, 5'd17}, {15'h0, 5'd17});
        #2;
        checkOutput("clearedR17", {32'h0, rd0[31:0]}, 64'h0);
        checkOutput("clearedPlainR0", {32'h0, rd1[63:32]}, 64'h0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, {5'(31 - i), 5'(i)},
                          {5'(i), 5'(31 - i), 5'(i), 5'(i)});
        end
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
